systolic_result_drain: RTL
==========================

SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

Interface
REQ-001 SHALL have parameter ACCUM_WIDTH, default 64, giving the width of each captured accumulator result.
REQ-002 SHALL have parameter OUT_WIDTH, default 32, giving the width of each streamed output element; the design SHALL require OUT_WIDTH < ACCUM_WIDTH.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port done_i, input, 1 bit: one-cycle pulse marking a completed 2x2 tile from the array.
REQ-006 SHALL have ports c00_i, c01_i, c10_i, c11_i, input, ACCUM_WIDTH bits each: tile results, signed, valid in the done_i cycle.
REQ-007 SHALL have port sat_en_i, input, 1 bit: 1 = saturate to OUT_WIDTH; 0 = truncate; sampled with done_i.
REQ-008 SHALL have port tile_ready_o, output, 1 bit: tile buffer can accept a tile.
REQ-009 SHALL have port out_valid_o, output, 1 bit: out_data_o holds a valid element.
REQ-010 SHALL have port out_ready_i, input, 1 bit: downstream accepts the element.
REQ-011 SHALL have port out_data_o, output, OUT_WIDTH bits: current element.
REQ-012 SHALL have port out_idx_o, output, 2 bits: element index, row-major: 0=c00, 1=c01, 2=c10, 3=c11.
REQ-013 SHALL have port out_last_o, output, 1 bit: high when out_idx_o==3.
REQ-014 SHALL have port out_sat_o, output, 1 bit: current element was clamped.
REQ-015 SHALL have port overflow_o, output, 1 bit: sticky tile-drop flag.
REQ-016 SHALL have port clear_ovf_i, input, 1 bit: clears overflow_o.
REQ-017 SHALL have port busy_o, output, 1 bit: at least one tile is buffered.

Function
REQ-018 SHALL hold a 2-entry FIFO of tiles; each entry stores four results plus its sat_en bit.
REQ-019 tile_ready_o SHALL equal (count < 2), where count is the number of buffered tiles.
REQ-020 On done_i with count < 2, the block SHALL capture c00_i..c11_i and sat_en_i into the tail entry at that edge.
REQ-021 On done_i with count == 2, the block SHALL drop the tile and set overflow_o, even if a pop occurs in the same cycle.
REQ-022 A capture and a pop in the same cycle SHALL leave count unchanged.
REQ-023 The state machine SHALL have states IDLE and STREAM.
REQ-024 IDLE -> STREAM SHALL occur when count becomes non-zero; STREAM -> IDLE SHALL occur on the final transfer when no other tile is buffered.
REQ-025 out_valid_o SHALL be high exactly in STREAM; first out_valid_o SHALL appear the cycle after the capturing done_i edge (latency 1).
REQ-026 A transfer SHALL occur on a rising edge with out_valid_o && out_ready_i.
REQ-027 Each transfer SHALL advance out_idx_o by 1; the transfer at idx 3 SHALL pop the head tile and wrap out_idx_o to 0.
REQ-028 Consecutive tiles SHALL stream back-to-back with no bubble when out_ready_i stays high.
REQ-029 While out_valid_o && !out_ready_i, out_data_o, out_idx_o, out_last_o and out_sat_o SHALL remain stable.
REQ-030 Conversion when sat_en = 1: if the signed value > 2^(OUT_WIDTH-1)-1, output that maximum; if < -2^(OUT_WIDTH-1), output that minimum; out_sat_o = 1 when clamped.
REQ-031 Conversion when sat_en = 0: output the low OUT_WIDTH bits; out_sat_o = 0.
REQ-032 clear_ovf_i SHALL clear overflow_o; a simultaneous drop SHALL win, leaving overflow_o = 1.
REQ-033 busy_o SHALL equal (count != 0).

Reset
REQ-034 While rst_i is high, the block SHALL set: count = 0, FIFO pointers 0, state IDLE, out_idx_o = 0, out_valid_o = 0, out_last_o = 0, out_sat_o = 0, out_data_o = 0, overflow_o = 0, busy_o = 0, tile_ready_o = 1.
REQ-035 Reset asserted mid-stream SHALL discard all buffered tiles immediately (asynchronous), with no further transfers after release until a new done_i.
REQ-036 FIFO payload storage SHALL NOT require reset.

Verification
REQ-037 Basic stream: done_i with c = {5, 6, 7, 8}, sat_en = 0, out_ready_i = 1 -> out_valid_o the next cycle; data 5, 6, 7, 8 on idx 0..3; out_last_o high on 8; then IDLE.
REQ-038 Saturation: sat_en = 1, c00 = 0x1_0000_0000, c01 = -2^40, c10 = -3, c11 = 0x7FFF_FFFF -> 0x7FFF_FFFF (sat = 1), 0x8000_0000 (sat = 1), 0xFFFF_FFFD (sat = 0), 0x7FFF_FFFF (sat = 0).
REQ-039 Backpressure: out_ready_i low for 3 cycles at idx 1 -> out_data_o and out_idx_o held stable; idx 2 is presented only after out_ready_i returns high.
REQ-040 Overflow: three done_i pulses with out_ready_i = 0 -> third tile dropped, overflow_o = 1, tile_ready_o = 0; then clear_ovf_i -> overflow_o = 0; the two stored tiles stream in order.
REQ-041 Simultaneous events: count = 1, done_i coincident with the idx-3 transfer -> count stays 1; next tile starts at idx 0 the following cycle with no bubble.
REQ-042 Reset mid-stream: assert rst_i at idx 2 -> out_valid_o = 0, busy_o = 0 immediately; no stale elements are emitted after release.

Source files
------------

// File: rtl/systolic_result_drain.sv
// Buffers completed 2x2 accumulator tiles in a two-deep FIFO and streams them out
// one element per handshake, optionally saturating each result to OUT_WIDTH.
module systolic_result_drain #(
  parameter int ACCUM_WIDTH = 64,
  parameter int OUT_WIDTH   = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          done_i,
  input  logic signed [ACCUM_WIDTH-1:0] c00_i,
  input  logic signed [ACCUM_WIDTH-1:0] c01_i,
  input  logic signed [ACCUM_WIDTH-1:0] c10_i,
  input  logic signed [ACCUM_WIDTH-1:0] c11_i,
  input  logic                          sat_en_i,
  output logic                          tile_ready_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [OUT_WIDTH-1:0]          out_data_o,
  output logic [1:0]                    out_idx_o,
  output logic                          out_last_o,
  output logic                          out_sat_o,
  output logic                          overflow_o,
  input  logic                          clear_ovf_i,
  output logic                          busy_o
);

  if (OUT_WIDTH >= ACCUM_WIDTH) begin : g_width_check
    $error("systolic_result_drain: OUT_WIDTH must be narrower than ACCUM_WIDTH");
  end

  localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [ACCUM_WIDTH-1:0] MAX_V = {{(ACCUM_WIDTH-OUT_WIDTH){1'b0}}, OUT_MAX};
  localparam logic signed [ACCUM_WIDTH-1:0] MIN_V = {{(ACCUM_WIDTH-OUT_WIDTH){1'b1}}, OUT_MIN};

  typedef enum logic {IDLE, STREAM} state_t;

  // Result layout: {clamped, data}
  function automatic logic [OUT_WIDTH:0] sat_conv(input logic signed [ACCUM_WIDTH-1:0] v,
                                                  input logic en);
    if (!en)        return {1'b0, v[OUT_WIDTH-1:0]};
    if (v > MAX_V)  return {1'b1, OUT_MAX};
    if (v < MIN_V)  return {1'b1, OUT_MIN};
    return {1'b0, v[OUT_WIDTH-1:0]};
  endfunction

  logic signed [ACCUM_WIDTH-1:0] mem [0:1][0:3];
  logic                          mem_sat [0:1];
  logic                          wr_ptr, rd_ptr;
  logic [1:0]                    count;
  logic [1:0]                    idx;
  logic                          ovf;
  state_t                        state;
  logic                          capture, xfer, pop;
  logic [OUT_WIDTH:0]            conv;

  assign capture = done_i && (count != 2'd2);
  assign xfer    = out_valid_o && out_ready_i;
  assign pop     = xfer && (idx == 2'd3);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      idx    <= 2'd0;
      ovf    <= 1'b0;
    end else begin
      if (capture) wr_ptr <= ~wr_ptr;
      if (pop)     rd_ptr <= ~rd_ptr;
      case ({capture, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (xfer) idx <= idx + 2'd1;
      // A dropped tile outranks a clear request in the same cycle
      if (done_i && (count == 2'd2)) ovf <= 1'b1;
      else if (clear_ovf_i)          ovf <= 1'b0;
      case (state)
        IDLE:    if (capture) state <= STREAM;
        STREAM:  if (pop && (count == 2'd1) && !capture) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Payload storage carries no reset; the head is only read while a tile is buffered
  always_ff @(posedge clk_i) begin
    if (capture) begin
      mem[wr_ptr][0]  <= c00_i;
      mem[wr_ptr][1]  <= c01_i;
      mem[wr_ptr][2]  <= c10_i;
      mem[wr_ptr][3]  <= c11_i;
      mem_sat[wr_ptr] <= sat_en_i;
    end
  end

  // Writes go to the tail slot, so the head element stays stable under backpressure
  assign conv         = sat_conv(mem[rd_ptr][idx], mem_sat[rd_ptr]);
  assign out_valid_o  = (state == STREAM);
  assign out_data_o   = out_valid_o ? conv[OUT_WIDTH-1:0] : '0;
  assign out_sat_o    = out_valid_o && conv[OUT_WIDTH];
  assign out_idx_o    = idx;
  assign out_last_o   = out_valid_o && (idx == 2'd3);
  assign overflow_o   = ovf;
  assign busy_o       = (count != 2'd0);
  assign tile_ready_o = (count != 2'd2);

endmodule
